// File: rtl/cpu_obi_timeout_guard.sv
// OBI timeout guard between a CPU data port and the system bus: fakes a grant
// and/or an error response when the bus stalls, and records timeout statistics.
package cpu_obi_timeout_guard_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module cpu_obi_timeout_guard
  import cpu_obi_timeout_guard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    cpu_req_i,
  output obi_resp_t   cpu_resp_o,
  output obi_req_t    bus_req_o,
  input  obi_resp_t   bus_resp_i,
  output logic        timeout_o,
  output logic [31:0] err_addr_o,
  output logic [7:0]  err_cnt_o
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WAIT_RSP, FAKE_GNT, FAKE_RSP, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        timeout;
  logic        cnt_last;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    timeout    = 1'b0;
    cnt_last   = (cnt_q == CNT_LAST);
    // Address, data and strobes always follow the CPU; only req is gated.
    bus_req_o         = cpu_req_i;
    bus_req_o.req     = 1'b0;
    cpu_resp_o.gnt    = 1'b0;
    cpu_resp_o.rvalid = 1'b0;
    cpu_resp_o.rdata  = bus_resp_i.rdata;

    unique case (state_q)
      IDLE: begin
        bus_req_o.req  = cpu_req_i.req;
        cpu_resp_o.gnt = bus_resp_i.gnt;
        cnt_d          = '0;
        if (cpu_req_i.req) begin
          // A grant on the last allowed cycle wins over the timeout.
          if (bus_resp_i.gnt) begin
            state_d = WAIT_RSP;
            addr_d  = cpu_req_i.addr;
          end else if (cnt_last) begin
            state_d = FAKE_GNT;
            addr_d  = cpu_req_i.addr;
            timeout = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      FAKE_GNT: begin
        cpu_resp_o.gnt = 1'b1;
        state_d        = FAKE_RSP;
      end
      FAKE_RSP: begin
        cpu_resp_o.rvalid = 1'b1;
        cpu_resp_o.rdata  = ERR_RDATA;
        state_d           = IDLE;
      end
      WAIT_RSP: begin
        if (bus_resp_i.rvalid) begin
          cpu_resp_o.rvalid = 1'b1;
          state_d           = IDLE;
          cnt_d             = '0;
        end else if (cnt_last) begin
          cpu_resp_o.rvalid = 1'b1;
          cpu_resp_o.rdata  = ERR_RDATA;
          timeout           = 1'b1;
          state_d           = DRAIN;
          cnt_d             = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DRAIN: begin
        // The late response belongs to a transaction the CPU already closed.
        if (bus_resp_i.rvalid || cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if (timeout) begin
      err_addr_d = (state_q == IDLE) ? cpu_req_i.addr : addr_q;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign timeout_o  = timeout;
  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_cpu_obi_timeout_guard.sv
// Directed bench for cpu_obi_timeout_guard with TIMEOUT_CYCLES=4; responses
// are checked by a scoreboard monitor against a queue of expected rdata.
module tb_cpu_obi_timeout_guard;
  import cpu_obi_timeout_guard_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  obi_req_t    cpu_req;
  obi_resp_t   cpu_resp;
  obi_req_t    bus_req;
  obi_resp_t   bus_resp;
  logic        timeout;
  logic [31:0] err_addr;
  logic [7:0]  err_cnt;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_pulse = 0;
  logic [31:0] exp_q[$];

  cpu_obi_timeout_guard #(
    .TIMEOUT_CYCLES(4),
    .ERR_RDATA     (32'hDEAD_BEEF)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .cpu_req_i (cpu_req),
    .cpu_resp_o(cpu_resp),
    .bus_req_o (bus_req),
    .bus_resp_i(bus_resp),
    .timeout_o (timeout),
    .err_addr_o(err_addr),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end else begin
      $display("check %s: %h", nm, act);
    end
  endtask

  // Scoreboard monitor: every CPU-visible response must match the queue head.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (timeout) n_pulse++;
        if (cpu_resp.rvalid) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rvalid: got rdata %h, expected no response", cpu_resp.rdata);
          end else begin
            e = exp_q.pop_front();
            if (cpu_resp.rdata !== e) begin
              n_fail++;
              $display("FAIL rsp_rdata: got %h, expected %h", cpu_resp.rdata, e);
            end else begin
              $display("rsp rdata %h", cpu_resp.rdata);
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_req  = '0;
    bus_resp = '0;
    cpu_req.be = 4'hF;
    rst_n    = 1'b0;
    repeat (2) step();
    mid();
    chk("rst_timeout",  32'(timeout), 32'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_err_cnt",  32'(err_cnt), 32'h0);
    chk("rst_rvalid",   32'(cpu_resp.rvalid), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Normal read: gnt at cycle 0, rvalid at cycle 3.
    cpu_req.req  = 1'b1;
    cpu_req.addr = 32'h0000_1000;
    bus_resp.gnt = 1'b1;
    exp_q.push_back(32'h1234_5678);
    mid();
    chk("t1_cpu_gnt",  32'(cpu_resp.gnt), 32'h1);
    chk("t1_bus_req",  32'(bus_req.req), 32'h1);
    chk("t1_bus_addr", bus_req.addr, 32'h0000_1000);
    step();
    cpu_req.addr = 32'h0000_2000;
    mid();
    chk("t1_wait_req_gated", 32'(bus_req.req), 32'h0);
    chk("t1_wait_addr_fwd",  bus_req.addr, 32'h0000_2000);
    chk("t1_wait_gnt_gated", 32'(cpu_resp.gnt), 32'h0);
    step();
    cpu_req.req  = 1'b0;
    bus_resp.gnt = 1'b0;
    step();
    bus_resp.rvalid = 1'b1;
    bus_resp.rdata  = 32'h1234_5678;
    mid();
    chk("t1_rvalid_same_cycle", 32'(cpu_resp.rvalid), 32'h1);
    step();
    bus_resp.rvalid = 1'b0;
    chk("t1_no_pulse", 32'(n_pulse), 32'h0);

    // Grant timeout: fake gnt then fake error response.
    cpu_req.req  = 1'b1;
    cpu_req.addr = 32'h0000_A200;
    exp_q.push_back(32'hDEAD_BEEF);
    step();
    step();
    mid();
    chk("t2_no_early_timeout", 32'(timeout), 32'h0);
    step();
    mid();
    chk("t2_timeout_4th", 32'(timeout), 32'h1);
    chk("t2_no_gnt_yet",  32'(cpu_resp.gnt), 32'h0);
    step();
    mid();
    chk("t2_fake_gnt",     32'(cpu_resp.gnt), 32'h1);
    chk("t2_fake_gnt_req", 32'(bus_req.req), 32'h0);
    step();
    cpu_req.req = 1'b0;
    step();
    mid();
    chk("t2_err_cnt",  32'(err_cnt), 32'h1);
    chk("t2_err_addr", err_addr, 32'h0000_A200);

    // Response timeout, late rvalid swallowed, next request accepted.
    step();
    cpu_req.req  = 1'b1;
    cpu_req.addr = 32'h0000_3300;
    bus_resp.gnt = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    step();
    cpu_req.req  = 1'b0;
    bus_resp.gnt = 1'b0;
    step();
    step();
    step();
    mid();
    chk("t3_timeout_wait", 32'(timeout), 32'h1);
    step();
    step();
    bus_resp.rvalid = 1'b1;
    bus_resp.rdata  = 32'hBAD0_BAD0;
    mid();
    chk("t3_late_swallowed", 32'(cpu_resp.rvalid), 32'h0);
    step();
    bus_resp.rvalid = 1'b0;
    cpu_req.req  = 1'b1;
    cpu_req.addr = 32'h0000_4400;
    bus_resp.gnt = 1'b1;
    exp_q.push_back(32'hCAFE_F00D);
    mid();
    chk("t3_next_gnt", 32'(cpu_resp.gnt), 32'h1);
    step();
    cpu_req.req     = 1'b0;
    bus_resp.gnt    = 1'b0;
    bus_resp.rvalid = 1'b1;
    bus_resp.rdata  = 32'hCAFE_F00D;
    step();
    bus_resp.rvalid = 1'b0;
    mid();
    chk("t3_err_cnt",  32'(err_cnt), 32'h2);
    chk("t3_err_addr", err_addr, 32'h0000_3300);

    // Grant and response each arrive exactly on the timeout cycle.
    step();
    cpu_req.req  = 1'b1;
    cpu_req.addr = 32'h0000_5500;
    exp_q.push_back(32'h5A5A_1234);
    step();
    step();
    step();
    bus_resp.gnt = 1'b1;
    mid();
    chk("t4_gnt_wins",  32'(cpu_resp.gnt), 32'h1);
    chk("t4_no_pulse1", 32'(timeout), 32'h0);
    step();
    cpu_req.req  = 1'b0;
    bus_resp.gnt = 1'b0;
    step();
    step();
    step();
    bus_resp.rvalid = 1'b1;
    bus_resp.rdata  = 32'h5A5A_1234;
    mid();
    chk("t4_no_pulse2", 32'(timeout), 32'h0);
    step();
    bus_resp.rvalid = 1'b0;
    mid();
    chk("t4_err_cnt", 32'(err_cnt), 32'h2);
    chk("t4_pulses",  32'(n_pulse), 32'h2);

    // Reset in the middle of WAIT_RSP drops the transaction.
    step();
    cpu_req.req  = 1'b1;
    cpu_req.addr = 32'h0000_6600;
    bus_resp.gnt = 1'b1;
    step();
    cpu_req.req  = 1'b0;
    bus_resp.gnt = 1'b0;
    step();
    rst_n = 1'b0;
    mid();
    chk("t5_rst_timeout",  32'(timeout), 32'h0);
    chk("t5_rst_err_cnt",  32'(err_cnt), 32'h0);
    chk("t5_rst_err_addr", err_addr, 32'h0);
    chk("t5_rst_rvalid",   32'(cpu_resp.rvalid), 32'h0);
    chk("t5_rst_gnt",      32'(cpu_resp.gnt), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      bus_resp.rvalid = (i == 2);
      bus_resp.rdata  = 32'h0BAD_0BAD;
      if (i == 2) begin
        mid();
        chk("t5_no_rvalid_after_rst", 32'(cpu_resp.rvalid), 32'h0);
      end
    end
    step();
    bus_resp.rvalid = 1'b0;

    // Saturating error counter over 300 grant timeouts.
    for (int i = 0; i < 300; i++) begin
      cpu_req.req  = 1'b1;
      cpu_req.addr = 32'h1000_0000 + 32'(i);
      exp_q.push_back(32'hDEAD_BEEF);
      repeat (6) step();
    end
    cpu_req.req = 1'b0;
    step();
    mid();
    chk("t6_err_cnt_sat", 32'(err_cnt), 32'h0000_00FF);
    chk("t6_err_addr",    err_addr, 32'h1000_012B);
    chk("t6_pulses",      32'(n_pulse), 32'd302);
    chk("pending_rsp",    32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
